// File: rtl/multi_domain_control.sv
// Multi-domain reset and clock-enable sequencer. It qualifies clock lock, holds reset, releases
// the domains one at a time, and supports per-domain soft resets.
module multi_domain_control #(
  parameter int unsigned DOMAINS     = 4,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               async_rst,
  input  logic               clk_lock,
  input  logic [DOMAINS-1:0] soft_rst,
  output logic [DOMAINS-1:0] clk_en,
  output logic [DOMAINS-1:0] sync_rst,
  output logic [DOMAINS-1:0] init,
  output logic               ready,
  output logic [7:0]         lock_loss_count
);
  localparam int unsigned FiltW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam int unsigned GapW  = $clog2(STAGE_GAP + 1);
  localparam int unsigned DomW  = $clog2(DOMAINS + 1);

  typedef enum logic [2:0] {StReset, StWaitLock, StHold, StRelease, StRun} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [FiltW-1:0]     filt_q, filt_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [DomW-1:0]      dom_q, dom_d;
  logic [HoldW-1:0]     soft_q [DOMAINS];
  logic [HoldW-1:0]     soft_d [DOMAINS];
  logic [DOMAINS-1:0]   clk_en_d, sync_rst_d, init_d;
  logic [7:0]           loss_d;
  logic                 ready_d, soft_busy;

  always_comb begin
    state_d    = state_q;
    filt_d     = filt_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    dom_d      = dom_q;
    soft_d     = soft_q;
    clk_en_d   = clk_en;
    sync_rst_d = sync_rst;
    init_d     = '0;
    loss_d     = lock_loss_count;
    unique case (state_q)
      StReset: begin
        if (rst_sync_q[SYNC_STAGES-1]) begin
          state_d = StWaitLock;
          filt_d  = '0;
        end
      end
      StWaitLock: begin
        if (!clk_lock) begin
          filt_d = '0;
        end else if (filt_q == FiltW'(LOCK_FILTER - 1)) begin
          state_d = StHold;
          filt_d  = '0;
          hold_d  = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldW'(RST_HOLD - 1)) begin
          state_d       = StRelease;
          dom_d         = DomW'(1);
          gap_d         = '0;
          sync_rst_d[0] = 1'b0;
          clk_en_d[0]   = 1'b1;
          init_d[0]     = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRelease: begin
        // dom_q is the next domain to release; reaching DOMAINS means all are out
        if (dom_q == DomW'(DOMAINS)) begin
          state_d = StRun;
        end else if (gap_q == GapW'(STAGE_GAP - 1)) begin
          gap_d = '0;
          dom_d = dom_q + 1'b1;
          for (int i = 0; i < DOMAINS; i++) begin
            if (dom_q == DomW'(i)) begin
              sync_rst_d[i] = 1'b0;
              clk_en_d[i]   = 1'b1;
              init_d[i]     = 1'b1;
            end
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StRun: begin
        for (int i = 0; i < DOMAINS; i++) begin
          if (soft_rst[i]) begin
            soft_d[i]     = HoldW'(RST_HOLD);
            sync_rst_d[i] = 1'b1;
            clk_en_d[i]   = 1'b0;
          end else if (soft_q[i] == HoldW'(1)) begin
            soft_d[i]     = '0;
            sync_rst_d[i] = 1'b0;
            clk_en_d[i]   = 1'b1;
            init_d[i]     = 1'b1;
          end else if (soft_q[i] != '0) begin
            soft_d[i] = soft_q[i] - 1'b1;
          end
        end
      end
      default: state_d = StReset;
    endcase

    // Lock loss overrides everything, including pending soft holds
    if (!clk_lock && (state_q inside {StHold, StRelease, StRun})) begin
      state_d    = StWaitLock;
      filt_d     = '0;
      sync_rst_d = '1;
      clk_en_d   = '0;
      init_d     = '0;
      for (int i = 0; i < DOMAINS; i++) soft_d[i] = '0;
      if (lock_loss_count != 8'hFF) loss_d = lock_loss_count + 8'd1;
    end

    soft_busy = 1'b0;
    for (int i = 0; i < DOMAINS; i++) soft_busy = soft_busy | (soft_d[i] != '0);
    ready_d = (state_d == StRun) && !soft_busy;
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      rst_sync_q      <= '0;
      state_q         <= StReset;
      filt_q          <= '0;
      hold_q          <= '0;
      gap_q           <= '0;
      dom_q           <= '0;
      for (int i = 0; i < DOMAINS; i++) soft_q[i] <= '0;
      clk_en          <= '0;
      sync_rst        <= '1;
      init            <= '0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      rst_sync_q      <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q         <= state_d;
      filt_q          <= filt_d;
      hold_q          <= hold_d;
      gap_q           <= gap_d;
      dom_q           <= dom_d;
      for (int i = 0; i < DOMAINS; i++) soft_q[i] <= soft_d[i];
      clk_en          <= clk_en_d;
      sync_rst        <= sync_rst_d;
      init            <= init_d;
      ready           <= ready_d;
      lock_loss_count <= loss_d;
    end
  end

endmodule

// File: tb/tb_multi_domain_control.sv
// Bench for multi_domain_control: directed timeline checks plus random lock/soft-reset traffic
// compared against an event-time reference model.
module tb_multi_domain_control;
  localparam int D  = 4;
  localparam int RH = 16;
  localparam int SG = 4;
  localparam int LF = 8;

  logic         clk = 1'b0;
  logic         async_rst;
  logic         clk_lock;
  logic [D-1:0] soft_rst;
  logic [D-1:0] clk_en, sync_rst, init;
  logic         ready;
  logic [7:0]   lock_loss_count;

  int total = 0;
  int bad   = 0;

  // Reference model: edge index n, lock-qualification edge q (-1 when unqualified),
  // and per-domain soft-hold release edges.
  int n = 0;
  int wait_from = 0;
  int q = -1;
  int streak = 0;
  int loss = 0;
  int soft_rel [D];
  logic [D-1:0] e_clk_en, e_sync_rst, e_init;
  logic         e_ready;

  multi_domain_control #(
    .DOMAINS(D), .RST_HOLD(RH), .STAGE_GAP(SG), .LOCK_FILTER(LF), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .async_rst(async_rst), .clk_lock(clk_lock), .soft_rst(soft_rst),
    .clk_en(clk_en), .sync_rst(sync_rst), .init(init), .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q = -1;
    streak = 0;
    loss = 0;
    for (int i = 0; i < D; i++) soft_rel[i] = -1;
  endtask

  task automatic model_step(input logic lk, input logic [D-1:0] sr);
    int run_edge;
    int rel;
    if (q < 0) begin
      if (n > wait_from) begin
        streak = lk ? streak + 1 : 0;
        if (streak == LF) begin
          q = n;
          streak = 0;
        end
      end
    end else if (!lk) begin
      q = -1;
      wait_from = n;
      streak = 0;
      loss = (loss < 255) ? loss + 1 : 255;
      for (int i = 0; i < D; i++) soft_rel[i] = -1;
    end else if (n > q + RH + (D - 1) * SG + 1) begin
      for (int i = 0; i < D; i++) if (sr[i]) soft_rel[i] = n + RH;
    end
    run_edge = q + RH + (D - 1) * SG + 1;
    e_ready = (q >= 0) && (n >= run_edge);
    for (int k = 0; k < D; k++) begin
      e_init[k] = 1'b0;
      e_sync_rst[k] = 1'b1;
      e_clk_en[k] = 1'b0;
      if (q >= 0) begin
        rel = q + RH + k * SG;
        if (n >= rel && soft_rel[k] <= n) begin
          e_sync_rst[k] = 1'b0;
          e_clk_en[k] = 1'b1;
        end
        if (n == rel || n == soft_rel[k]) e_init[k] = 1'b1;
        if (soft_rel[k] > n) e_ready = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic lk, input logic [D-1:0] sr);
    clk_lock = lk;
    soft_rst = sr;
    @(posedge clk);
    model_step(lk, sr);
    #1;
    check("clk_en", clk_en, e_clk_en);
    check("sync_rst", sync_rst, e_sync_rst);
    check("init", init, e_init);
    check("ready", ready, e_ready);
    check("lock_loss_count", lock_loss_count, loss);
    n++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_clk_en"}, clk_en, 0);
    check({tag, "_sync_rst"}, sync_rst, {D{1'b1}});
    check({tag, "_init"}, init, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_loss"}, lock_loss_count, 0);
  endtask

  task automatic assert_rst();
    #2;
    async_rst = 1'b0;
    #1;
    check_reset("async_abort");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    async_rst = 1'b1;
    wait_from = n + 2;
  endtask

  initial begin
    logic [D-1:0] ei;
    logic [D-1:0] rs;
    async_rst = 1'b0;
    clk_lock = 1'b1;
    soft_rst = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("por");
    end

    // Power-up timeline with lock held high
    release_rst();
    for (int j = 0; j < 40; j++) begin
      cycle(1'b1, '0);
      case (j)
        26: ei = 4'b0001;
        30: ei = 4'b0010;
        34: ei = 4'b0100;
        38: ei = 4'b1000;
        default: ei = 4'b0000;
      endcase
      check("pwr_init_edge", init, ei);
      check("pwr_ready_edge", ready, (j >= 39));
    end
    check("pwr_sync_rst", sync_rst, 0);
    check("pwr_clk_en", clk_en, 4'hF);

    // Lock loss in RUN, then requalification
    cycle(1'b0, '0);
    check("loss_sync_rst", sync_rst, 4'hF);
    check("loss_clk_en", clk_en, 0);
    check("loss_ready", ready, 0);
    check("loss_count", lock_loss_count, 1);
    repeat (45) cycle(1'b1, '0);
    check("requal_ready", ready, 1);

    // Soft reset of domain 2
    cycle(1'b1, 4'b0100);
    check("soft2_clk_en", clk_en, 4'b1011);
    for (int j = 1; j <= 20; j++) begin
      cycle(1'b1, '0);
      check("soft2_init", init[2], (j == 16));
      check("soft2_clk_en_run", clk_en, (j >= 16) ? 4'hF : 4'b1011);
      check("soft2_ready", ready, (j >= 16));
    end

    // Soft reset of domain 1, re-pulsed 10 cycles into the hold
    cycle(1'b1, 4'b0010);
    repeat (9) cycle(1'b1, '0);
    cycle(1'b1, 4'b0010);
    for (int j = 1; j <= 20; j++) begin
      cycle(1'b1, '0);
      check("soft1_restart_init", init[1], (j == 16));
    end

    // Random lock drops and soft-reset requests
    for (int j = 0; j < 800; j++) begin
      rs = ($urandom_range(0, 9) == 0) ? D'($urandom) : '0;
      cycle(($urandom_range(0, 24) != 0), rs);
    end

    // Filter glitch in WAIT_LOCK, then async abort after domain 1 release
    assert_rst();
    release_rst();
    for (int j = 0; j < 38; j++) begin
      cycle((j != 8), '0);
      check("glitch_init0", init[0], (j == 32));
      check("glitch_loss", lock_loss_count, 0);
    end
    check("mid_release_clk_en", clk_en, 4'b0011);
    assert_rst();

    // Lock-loss counter saturation
    release_rst();
    repeat (2) cycle(1'b1, '0);
    for (int j = 0; j < 260; j++) begin
      repeat (LF) cycle(1'b1, '0);
      cycle(1'b0, '0);
    end
    check("loss_saturate", lock_loss_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
